vga_grid_renderer: RTL and testbench

//  Parametrised successor VGA front end: one-clock timing generator plus grid renderer for ROWS x COLS board.

---
 rtl/vga_grid_pkg.sv | 32 +++
 rtl/vga_timing_gen.sv | 79 +++++++
 rtl/vga_grid_renderer.sv | 239 +++++++++++++++++++++++
 tb/tb_vga_grid_renderer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vga_grid_pkg.sv
// Shared types, colours and timing helpers for the VGA grid renderer.
package vga_grid_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        P1     = 2'b01,
        P2     = 2'b10,
        HILITE = 2'b11
    } cell_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK  = 24'h000000;
    localparam rgb_t RGB_BLUE   = 24'h0000FF;
    localparam rgb_t RGB_WHITE  = 24'hFFFFFF;
    localparam rgb_t RGB_RED    = 24'hFF0000;
    localparam rgb_t RGB_YELLOW = 24'hFFFF00;
    localparam rgb_t RGB_GREEN  = 24'h00FF00;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel clock-enable divider, raster counters and raw (undelayed) sync/active.
module vga_timing_gen
    import vga_grid_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_TOT    = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    parameter int V_TOT    = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    parameter int HW       = $clog2(H_TOT),
    parameter int VW       = $clog2(V_TOT)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic          o_pix_en,
    output logic          o_vga_clk,
    output logic [HW-1:0] o_hcnt,
    output logic [VW-1:0] o_vcnt,
    output logic          o_hs_raw,
    output logic          o_vs_raw,
    output logic          o_active,
    output logic          o_frame_start
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_next;
    logic          w_pix_en;
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          r_vga_clk;

    assign w_pix_en   = (int'(r_div) == CLK_DIV - 1);
    assign w_div_next = w_pix_en ? '0 : r_div + 1'b1;

    // Divider; vga_clk is registered from the next count so it is high for the first half of each pixel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div     <= '0;
            r_vga_clk <= 1'b0;
        end else begin
            r_div     <= w_div_next;
            r_vga_clk <= (int'(w_div_next) < CLK_DIV / 2);
        end
    end

    // Raster counters advance once per pixel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_pix_en) begin
            if (int'(r_hcnt) == H_TOT - 1) begin
                r_hcnt <= '0;
                if (int'(r_vcnt) == V_TOT - 1) r_vcnt <= '0;
                else                           r_vcnt <= r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    assign o_pix_en      = w_pix_en;
    assign o_vga_clk     = r_vga_clk;
    assign o_hcnt        = r_hcnt;
    assign o_vcnt        = r_vcnt;
    assign o_hs_raw      = !((int'(r_hcnt) >= H_ACTIVE + H_FP) && (int'(r_hcnt) < H_ACTIVE + H_FP + H_SYNC));
    assign o_vs_raw      = !((int'(r_vcnt) >= V_ACTIVE + V_FP) && (int'(r_vcnt) < V_ACTIVE + V_FP + V_SYNC));
    assign o_active      = (int'(r_hcnt) < H_ACTIVE) && (int'(r_vcnt) < V_ACTIVE);
    assign o_frame_start = w_pix_en && (r_hcnt == '0) && (r_vcnt == '0);

endmodule

// File: rtl/vga_grid_renderer.sv
// Board renderer: cell tracking, per-frame snapshot, blink phase and a 2-stage pixel pipeline.
module vga_grid_renderer
    import vga_grid_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int ROWS         = 6,
    parameter int COLS         = 7,
    parameter int CELL         = 64,
    parameter int GRID_X0      = 96,
    parameter int GRID_Y0      = 48,
    parameter int RADIUS       = 26,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     visible,
    input  logic [2*ROWS*COLS-1:0]   board,
    output logic                     vga_clk,
    output logic                     vga_hs,
    output logic                     vga_vs,
    output logic                     vga_blk,
    output logic                     vga_sync,
    output logic [7:0]               red,
    output logic [7:0]               green,
    output logic [7:0]               blue,
    output logic                     frame_start
);

    localparam int H_TOT  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW     = $clog2(H_TOT);
    localparam int VW     = $clog2(V_TOT);
    localparam int CW     = $clog2(COLS + 1);
    localparam int RW     = $clog2(ROWS + 1);
    localparam int OW     = $clog2(CELL);
    localparam int FW     = $clog2(BLINK_FRAMES + 1);
    localparam int GRID_X1 = GRID_X0 + COLS * CELL;
    localparam int GRID_Y1 = GRID_Y0 + ROWS * CELL;
    localparam int R2     = RADIUS * RADIUS;

    logic          w_pix_en;
    logic [HW-1:0] w_hcnt;
    logic [VW-1:0] w_vcnt;
    logic          w_hs_raw;
    logic          w_vs_raw;
    logic          w_active;

    vga_timing_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk         (clk),
        .i_rst_n       (rst),
        .o_pix_en      (w_pix_en),
        .o_vga_clk     (vga_clk),
        .o_hcnt        (w_hcnt),
        .o_vcnt        (w_vcnt),
        .o_hs_raw      (w_hs_raw),
        .o_vs_raw      (w_vs_raw),
        .o_active      (w_active),
        .o_frame_start (frame_start)
    );

    logic [CW-1:0] r_col;
    logic [OW-1:0] r_xoff;
    logic [RW-1:0] r_row;
    logic [OW-1:0] r_yoff;
    logic [CW-1:0] w_col;
    logic [OW-1:0] w_xoff;
    logic [RW-1:0] w_row;
    logic [OW-1:0] w_yoff;
    logic          w_line_end;

    // The registered trackers hold the position of the current pixel; at the grid
    // origin they are overridden to zero so the reset lines up with the pixel itself.
    assign w_col      = (int'(w_hcnt) == GRID_X0) ? '0 : r_col;
    assign w_xoff     = (int'(w_hcnt) == GRID_X0) ? '0 : r_xoff;
    assign w_row      = (int'(w_vcnt) == GRID_Y0) ? '0 : r_row;
    assign w_yoff     = (int'(w_vcnt) == GRID_Y0) ? '0 : r_yoff;
    assign w_line_end = w_pix_en && (int'(w_hcnt) == H_TOT - 1);

    // Column/x-offset tracking; col parks at COLS past the last cell until the next line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col  <= '0;
            r_xoff <= '0;
        end else if (w_pix_en && (int'(w_col) < COLS)) begin
            if (int'(w_xoff) == CELL - 1) begin
                r_xoff <= '0;
                r_col  <= w_col + 1'b1;
            end else begin
                r_xoff <= w_xoff + 1'b1;
                r_col  <= w_col;
            end
        end
    end

    // Row/y-offset tracking, stepped once per line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row  <= '0;
            r_yoff <= '0;
        end else if (w_line_end && (int'(w_row) < ROWS)) begin
            if (int'(w_yoff) == CELL - 1) begin
                r_yoff <= '0;
                r_row  <= w_row + 1'b1;
            end else begin
                r_yoff <= w_yoff + 1'b1;
                r_row  <= w_row;
            end
        end
    end

    logic [2*ROWS*COLS-1:0] r_shadow;
    logic [FW-1:0]          r_frame_cnt;
    logic                   r_blink;
    logic                   w_snap;

    assign w_snap = w_pix_en && (w_hcnt == '0) && (int'(w_vcnt) == V_ACTIVE);

    // Board snapshot and blink phase both update at the start of vertical blanking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow    <= '0;
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (w_snap) begin
            r_shadow <= board;
            if (int'(r_frame_cnt) == BLINK_FRAMES - 1) begin
                r_frame_cnt <= '0;
                r_blink     <= !r_blink;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    logic              w_in_grid;
    int                w_idx;
    logic signed [OW:0] w_dx;
    logic signed [OW:0] w_dy;

    assign w_in_grid = (int'(w_hcnt) >= GRID_X0) && (int'(w_hcnt) < GRID_X1) &&
                       (int'(w_vcnt) >= GRID_Y0) && (int'(w_vcnt) < GRID_Y1) &&
                       (int'(w_col) < COLS) && (int'(w_row) < ROWS);
    assign w_idx     = w_in_grid ? (int'(w_row) * COLS + int'(w_col)) : 0;
    assign w_dx      = $signed({1'b0, w_xoff}) - $signed((OW + 1)'(CELL / 2));
    assign w_dy      = $signed({1'b0, w_yoff}) - $signed((OW + 1)'(CELL / 2));

    cell_state_t        r_s1_cell;
    logic signed [OW:0] r_s1_dx;
    logic signed [OW:0] r_s1_dy;
    logic               r_s1_in_grid;
    logic               r_s1_active;
    logic               r_s1_hs;
    logic               r_s1_vs;

    // Stage 1: cell lookup, centre offsets, and first delay of the sync/active strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_cell    <= EMPTY;
            r_s1_dx      <= '0;
            r_s1_dy      <= '0;
            r_s1_in_grid <= 1'b0;
            r_s1_active  <= 1'b0;
            r_s1_hs      <= 1'b1;
            r_s1_vs      <= 1'b1;
        end else if (w_pix_en) begin
            r_s1_cell    <= w_in_grid ? cell_state_t'(r_shadow[2*w_idx +: 2]) : EMPTY;
            r_s1_dx      <= w_dx;
            r_s1_dy      <= w_dy;
            r_s1_in_grid <= w_in_grid;
            r_s1_active  <= w_active;
            r_s1_hs      <= w_hs_raw;
            r_s1_vs      <= w_vs_raw;
        end
    end

    int   w_d2;
    logic w_disc;
    rgb_t w_rgb;

    // Stage 2 colour select: disc test against the squared radius, then palette by cell state.
    always_comb begin
        w_d2   = int'(r_s1_dx) * int'(r_s1_dx) + int'(r_s1_dy) * int'(r_s1_dy);
        w_disc = (w_d2 <= R2);
        w_rgb  = RGB_BLACK;
        if (r_s1_active && visible && r_s1_in_grid) begin
            if (!w_disc) begin
                w_rgb = RGB_BLUE;
            end else begin
                case (r_s1_cell)
                    P1:      w_rgb = RGB_RED;
                    P2:      w_rgb = RGB_YELLOW;
                    HILITE:  w_rgb = r_blink ? RGB_GREEN : RGB_WHITE;
                    default: w_rgb = RGB_WHITE;
                endcase
            end
        end
    end

    rgb_t r_rgb;

    // Stage 2 output registers keep colour and sync aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgb   <= RGB_BLACK;
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
            vga_blk <= 1'b0;
        end else if (w_pix_en) begin
            r_rgb   <= w_rgb;
            vga_hs  <= r_s1_hs;
            vga_vs  <= r_s1_vs;
            vga_blk <= r_s1_active;
        end
    end

    assign red      = r_rgb.r;
    assign green    = r_rgb.g;
    assign blue     = r_rgb.b;
    assign vga_sync = 1'b0;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Directed bench on a reduced raster (40x30 pixels total, 4-pixel cells) so frames stay short.
module tb_vga_grid_renderer;

    localparam int D     = 2;
    localparam int H_TOT = 40;
    localparam int FRAME = 40 * 30 * D;

    localparam logic [31:0] BLACK  = 32'h000000;
    localparam logic [31:0] BLUE   = 32'h0000FF;
    localparam logic [31:0] WHITE  = 32'hFFFFFF;
    localparam logic [31:0] RED    = 32'hFF0000;
    localparam logic [31:0] YELLOW = 32'hFFFF00;
    localparam logic [31:0] GREEN  = 32'h00FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic        visible;
    logic [83:0] board;
    logic        vga_clk, vga_hs, vga_vs, vga_blk, vga_sync, frame_start;
    logic [7:0]  red, green, blue;

    vga_grid_renderer #(
        .CLK_DIV(2), .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(26), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .ROWS(6), .COLS(7), .CELL(4), .GRID_X0(2), .GRID_Y0(1),
        .RADIUS(1), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .visible(visible), .board(board),
        .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blk(vga_blk),
        .vga_sync(vga_sync), .red(red), .green(green), .blue(blue),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int elapsed  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        elapsed += n;
    endtask

    // Output for pixel (x,y) is stable after the pix_en edge of the following pixel.
    task automatic goto_pixel(input int x, input int y);
        int target;
        target = (y * H_TOT + x + 1) * D + 1;
        step(target - elapsed);
    endtask

    task automatic check_px(input string tag, input int x, input int y, input logic [31:0] exp);
        goto_pixel(x, y);
        check(tag, {8'h00, red, green, blue}, exp);
    endtask

    task automatic wait_fs(input string tag);
        int  n;
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < FRAME + 200) begin
            @(posedge clk);
            #1;
            n++;
            if (frame_start) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
        elapsed = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hs"},  {31'd0, vga_hs}, 32'd1);
        check({tag, "_vs"},  {31'd0, vga_vs}, 32'd1);
        check({tag, "_blk"}, {31'd0, vga_blk}, 32'd0);
        check({tag, "_rgb"}, {8'h00, red, green, blue}, BLACK);
        check({tag, "_fs"},  {31'd0, frame_start}, 32'd0);
        check({tag, "_clk"}, {31'd0, vga_clk}, 32'd0);
    endtask

    // From one frame_start to the next: period and per-frame sync/blank/colour totals.
    task automatic measure_frame(input string tag, input logic chk_rgb);
        int n, hs_low, vs_low, blk_hi, rgb_nz;
        n = 0; hs_low = 0; vs_low = 0; blk_hi = 0; rgb_nz = 0;
        while (n < FRAME + 200) begin
            @(posedge clk);
            #1;
            n++;
            if (!vga_hs) hs_low++;
            if (!vga_vs) vs_low++;
            if (vga_blk) blk_hi++;
            if ({red, green, blue} != 24'h0) rgb_nz++;
            if (frame_start) break;
        end
        check({tag, "_period"}, n, FRAME);
        check({tag, "_hs_low"}, hs_low, 4 * 30 * D);
        check({tag, "_vs_low"}, vs_low, 2 * H_TOT * D);
        check({tag, "_blk_hi"}, blk_hi, 32 * 26 * D);
        check({tag, "_sync"}, {31'd0, vga_sync}, 32'd0);
        if (chk_rgb) check({tag, "_rgb_nz"}, rgb_nz, 0);
        elapsed = 0;
    endtask

    initial begin
        rst     = 1'b0;
        visible = 1'b1;
        board   = '0;
        board[1:0]   = 2'b01;
        board[17:16] = 2'b11;

        repeat (3) @(posedge clk);
        #1;
        check_reset("rst_init");

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("fs_first", {31'd0, frame_start}, 32'd1);
        check("vga_clk_first", {31'd0, vga_clk}, 32'd0);
        elapsed = 0;

        // frame 1 renders the cleared snapshot; used for timing totals only
        measure_frame("f1", 1'b0);

        // frame 2: snapshot taken at end of frame 1
        check_px("px_0_0", 0, 0, BLACK);
        check("blk_0_0", {31'd0, vga_blk}, 32'd1);
        check_px("px_corner", 2, 1, BLUE);
        check_px("px_edge_out", 2, 3, BLUE);
        check_px("px_edge_in", 3, 3, RED);
        check_px("px_p1_centre", 4, 3, RED);
        check_px("px_right_out", 30, 3, BLACK);
        check("blk_right_out", {31'd0, vga_blk}, 32'd1);
        goto_pixel(33, 3);
        check("blk_hblank", {31'd0, vga_blk}, 32'd0);
        check("hs_before", {31'd0, vga_hs}, 32'd1);
        goto_pixel(35, 3);
        check("hs_in_sync", {31'd0, vga_hs}, 32'd0);
        check_px("px_hilite_f2", 8, 7, WHITE);
        check_px("px_empty_f2", 28, 23, WHITE);
        check_px("px_last_corner", 29, 24, BLUE);
        check_px("px_vblank", 4, 27, BLACK);
        check("blk_vblank", {31'd0, vga_blk}, 32'd0);
        check("vs_in_sync", {31'd0, vga_vs}, 32'd0);

        // frame 3: blink phase 1, board change mid-frame not yet visible
        wait_fs("fs_f3");
        check_px("px_hilite_f3", 8, 7, GREEN);
        step(12 * H_TOT * D - elapsed);
        board[83:82] = 2'b10;
        check_px("snap_old", 28, 23, WHITE);

        // frame 4: new snapshot visible, blink still phase 1
        wait_fs("fs_f4");
        check_px("px_hilite_f4", 8, 7, GREEN);
        check_px("snap_new", 28, 23, YELLOW);

        wait_fs("fs_f5");
        check_px("px_hilite_f5", 8, 7, WHITE);
        wait_fs("fs_f6");
        wait_fs("fs_f7");
        check_px("px_hilite_f7", 8, 7, GREEN);

        // invisible frame: timing unchanged, colour suppressed
        visible = 1'b0;
        wait_fs("fs_f8");
        measure_frame("invis", 1'b1);

        // mid-line async reset while a coloured pixel is on the outputs
        visible = 1'b1;
        check_px("px_before_rst", 4, 3, RED);
        rst = 1'b0;
        #1;
        check_reset("rst_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("fs_after_rst", {31'd0, frame_start}, 32'd1);
        elapsed = 0;
        check_px("px_shadow_cleared", 4, 3, WHITE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
